// File: rtl/mcdp_pkg.sv
// Shared types and instruction-field positions for the multi-cycle 16-bit datapath.
package mcdp_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 10;
    localparam int RS_MSB    = 9;
    localparam int RS_LSB    = 8;
    localparam int RT_MSB    = 7;
    localparam int RT_LSB    = 6;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;
    localparam int JADDR_MSB = 11;
    localparam int JADDR_LSB = 0;

    localparam logic [1:0] RA_IDX = 2'd3;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

endpackage

// File: rtl/mcdp_alu.sv
// Combinational ALU for the multi-cycle datapath; results wrap at DATA_W.
module mcdp_alu
    import mcdp_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = '0;
        case (alu_op_e'(op))
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            // Shift amount is limited to the low nibble of B.
            ALU_SLL: result = a << b[3:0];
            ALU_SRL: result = a >> b[3:0];
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/multicycle_datapath.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB datapath with req/valid memory ports.
// Optional performance counters are built when MCDP_PERF_CNT_EN is defined.
//
// Handshake: a port's req is high for the whole wait and the transfer completes
// in the cycle where req and valid are both high; req drops the next cycle.
module multicycle_datapath
    import mcdp_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 10,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic [15:0]       ir,
    input  logic              reg2_src,
    input  logic              reg_dest,
    input  logic              reg_write,
    input  logic              alu_src,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic              branch,
    input  logic              branch_ne,
    input  logic              jump,
    input  logic              jump_reg,
    input  logic [2:0]        alu_ctrl,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [PC_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_valid,
    output logic [PC_W-1:0]   pc,
    output logic              zero_flag,
    output logic              retire,
    output logic [31:0]       cycle_cnt,
    output logic [31:0]       instr_cnt,
    output state_e            fsmState
);

    state_e            state;
    logic [DATA_W-1:0] regs [4];
    logic [DATA_W-1:0] regA;
    logic [DATA_W-1:0] regB;
    logic [DATA_W-1:0] aluOut;
    logic [DATA_W-1:0] mdr;
    logic [PC_W-1:0]   nextPc;

    logic [DATA_W-1:0] aluB;
    logic [DATA_W-1:0] aluResult;
    logic              aluZero;
    logic [PC_W-1:0]   pcPlus1;
    logic [PC_W-1:0]   branchTgt;
    logic [PC_W-1:0]   jumpTgt;
    logic [PC_W-1:0]   execNextPc;
    logic              isCtrlFlow;
    logic              branchTaken;
    logic              retireNext;
    logic [1:0]        wbIdx;
    logic [DATA_W-1:0] wbData;

    assign aluB = alu_src ? {{(DATA_W-8){ir[IMM_MSB]}}, ir[IMM_MSB:IMM_LSB]} : regB;

    mcdp_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (regA),
        .b      (aluB),
        .op     (alu_ctrl),
        .result (aluResult),
        .zero   (aluZero)
    );

    // PC targets are formed in 16 bits and truncated, giving wrap modulo 2^PC_W.
    assign pcPlus1   = pc + PC_W'(1);
    assign branchTgt = PC_W'(16'(pc) + 16'd1 + sext8(ir[IMM_MSB:IMM_LSB]));
    assign jumpTgt   = PC_W'({4'b0000, ir[JADDR_MSB:JADDR_LSB]});

    assign isCtrlFlow  = jump | branch | branch_ne;
    assign branchTaken = (branch & aluZero) | (branch_ne & ~aluZero);

    always_comb begin
        execNextPc = pcPlus1;
        if (jump && jump_reg) begin
            execNextPc = regA[PC_W-1:0];
        end else if (jump) begin
            execNextPc = jumpTgt;
        end else if (branchTaken) begin
            execNextPc = branchTgt;
        end
    end

    // JAL defers its pc update to WB so the link value still sees the old pc.
    assign retireNext = ((state == EXEC) && isCtrlFlow && !(jump && reg_dest))
                      || ((state == MEM) && dmem_valid && mem_write)
                      || (state == WB);

    assign wbIdx  = reg_dest ? RA_IDX : ir[RD_MSB:RD_LSB];
    assign wbData = reg_dest ? DATA_W'(pcPlus1) : (mem_to_reg ? mdr : aluOut);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= PC_W'(RESET_PC);
            ir        <= '0;
            zero_flag <= 1'b0;
            retire    <= 1'b0;
            regA      <= '0;
            regB      <= '0;
            aluOut    <= '0;
            mdr       <= '0;
            nextPc    <= '0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            retire <= retireNext;
            case (state)
                FETCH: begin
                    if (imem_valid) begin
                        ir    <= imem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    regA  <= regs[ir[RS_MSB:RS_LSB]];
                    regB  <= regs[reg2_src ? ir[RD_MSB:RD_LSB] : ir[RT_MSB:RT_LSB]];
                    state <= EXEC;
                end
                EXEC: begin
                    aluOut    <= aluResult;
                    zero_flag <= aluZero;
                    nextPc    <= execNextPc;
                    if (isCtrlFlow) begin
                        if (jump && reg_dest) begin
                            state <= WB;
                        end else begin
                            pc    <= execNextPc;
                            state <= FETCH;
                        end
                    end else if (mem_read || mem_write) begin
                        state <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (dmem_valid) begin
                        if (mem_write) begin
                            pc    <= nextPc;
                            state <= FETCH;
                        end else begin
                            mdr   <= dmem_rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    if (reg_write) begin
                        regs[wbIdx] <= wbData;
                    end
                    pc    <= nextPc;
                    state <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    assign dmem_req   = (state == MEM);
    assign dmem_we    = (state == MEM) && mem_write;
    assign dmem_addr  = aluOut[PC_W-1:0];
    assign dmem_wdata = regB;
    assign fsmState   = state;

`ifdef MCDP_PERF_CNT_EN
    logic [31:0] cycleCntQ;
    logic [31:0] instrCntQ;

    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCntQ <= '0;
            instrCntQ <= '0;
        end else begin
            cycleCntQ <= cycleCntQ + 32'd1;
            if (retireNext) begin
                instrCntQ <= instrCntQ + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycleCntQ;
    assign instr_cnt = instrCntQ;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed bench for multicycle_datapath: acts as control unit and as latency-configurable memories.
module tb_multicycle_datapath;
    import mcdp_pkg::*;

    localparam int DATA_W = 16;
    localparam int PC_W   = 10;

    localparam logic [3:0] OP_R    = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_J    = 4'd2;
    localparam logic [3:0] OP_JAL  = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_BNE  = 4'd5;
    localparam logic [3:0] OP_JR   = 4'd6;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;

    logic              clk;
    logic              reset;
    logic              imem_req;
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_rdata;
    logic              imem_valid;
    logic [15:0]       ir;
    logic              reg2_src, reg_dest, reg_write, alu_src, mem_read, mem_write;
    logic              mem_to_reg, branch, branch_ne, jump, jump_reg;
    logic [2:0]        alu_ctrl;
    logic              dmem_req;
    logic              dmem_we;
    logic [PC_W-1:0]   dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_valid;
    logic [PC_W-1:0]   pc;
    logic              zero_flag;
    logic              retire;
    logic [31:0]       cycle_cnt;
    logic [31:0]       instr_cnt;
    state_e            fsmState;

    multicycle_datapath #(.DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC(0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .ir(ir),
        .reg2_src(reg2_src), .reg_dest(reg_dest), .reg_write(reg_write), .alu_src(alu_src),
        .mem_read(mem_read), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .branch(branch), .branch_ne(branch_ne), .jump(jump), .jump_reg(jump_reg),
        .alu_ctrl(alu_ctrl),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
        .pc(pc), .zero_flag(zero_flag), .retire(retire),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .fsmState(fsmState)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memories with programmable wait states
    logic [15:0]       imem [1024];
    logic [DATA_W-1:0] dmem [1024];
    int ilat = 0;
    int dlat = 0;
    int icnt = 0;
    int dcnt = 0;

    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign imem_valid = (imem_req === 1'b1) && (icnt == ilat);
    assign dmem_valid = (dmem_req === 1'b1) && (dcnt == dlat);

    always @(posedge clk) begin
        if (reset || imem_req !== 1'b1 || imem_valid) icnt <= 0;
        else icnt <= icnt + 1;
        if (reset || dmem_req !== 1'b1 || dmem_valid) dcnt <= 0;
        else dcnt <= dcnt + 1;
    end

    // control unit
    always_comb begin
        reg2_src   = 1'b0;
        reg_dest   = 1'b0;
        reg_write  = 1'b0;
        alu_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        branch     = 1'b0;
        branch_ne  = 1'b0;
        jump       = 1'b0;
        jump_reg   = 1'b0;
        alu_ctrl   = 3'd0;
        case (ir[15:12])
            OP_R:    begin reg_write = 1'b1; alu_ctrl = ir[2:0]; end
            OP_ADDI: begin reg_write = 1'b1; alu_src = 1'b1; end
            OP_J:    begin jump = 1'b1; end
            OP_JAL:  begin jump = 1'b1; reg_dest = 1'b1; reg_write = 1'b1; end
            OP_BEQ:  begin branch = 1'b1; reg2_src = 1'b1; alu_ctrl = 3'd1; end
            OP_BNE:  begin branch_ne = 1'b1; reg2_src = 1'b1; alu_ctrl = 3'd1; end
            OP_JR:   begin jump = 1'b1; jump_reg = 1'b1; end
            OP_LW:   begin mem_read = 1'b1; alu_src = 1'b1; reg_write = 1'b1; mem_to_reg = 1'b1; end
            OP_SW:   begin mem_write = 1'b1; alu_src = 1'b1; reg2_src = 1'b1; end
            default: ;
        endcase
    end

    function automatic logic [15:0] rtype(input logic [2:0] fn, input logic [1:0] rd,
                                          input logic [1:0] rs, input logic [1:0] rt);
        return {OP_R, rd, rs, rt, 3'b000, fn};
    endfunction

    function automatic logic [15:0] itype(input logic [3:0] op, input logic [1:0] rd,
                                          input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [15:0] jtype(input logic [3:0] op, input logic [11:0] a);
        return {op, a};
    endfunction

    // scoreboard
    int checks = 0;
    int errors = 0;
    int overlap = 0;
    logic [25:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // every completed store is matched against the next expected {addr, data}
    always @(negedge clk) begin
        if (imem_req === 1'b1 && dmem_req === 1'b1) overlap++;
        if (reset === 1'b0 && dmem_req === 1'b1 && dmem_we === 1'b1 && dmem_valid) begin
            chk("store_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("store", {6'b0, dmem_addr, dmem_wdata}, {6'b0, exp_q.pop_front()});
        end
    end

    // driver tasks
    task automatic wait_retire(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (retire !== 1'b1 && cyc < 200);
        chk("retire_seen", {31'b0, retire}, 32'd1);
    endtask

    task automatic step(input string tag, input logic [PC_W-1:0] exp_pc, input int exp_cyc);
        int cyc;
        wait_retire(cyc);
        chk({tag, "_pc"}, 32'(pc), 32'(exp_pc));
        if (exp_cyc > 0) chk({tag, "_cpi"}, cyc, exp_cyc);
    endtask

    int lw_cyc, lw_req, lw_bad;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            imem[i] = 16'h0000;
            dmem[i] = '0;
        end
        dmem[10'h020] = 16'hBEEF;

        imem[10'h000] = itype(OP_ADDI, 2'd1, 2'd0, 8'hFD);
        imem[10'h001] = itype(OP_ADDI, 2'd2, 2'd0, 8'h07);
        imem[10'h002] = rtype(3'd4, 2'd2, 2'd1, 2'd2);
        imem[10'h003] = jtype(OP_J, 12'h3FE);
        imem[10'h3FE] = itype(OP_BEQ, 2'd0, 2'd0, 8'h05);
        imem[10'h004] = itype(OP_SW, 2'd1, 2'd0, 8'h11);
        imem[10'h005] = itype(OP_SW, 2'd2, 2'd0, 8'h10);
        imem[10'h006] = rtype(3'd5, 2'd2, 2'd2, 2'd1);
        imem[10'h007] = rtype(3'd6, 2'd1, 2'd1, 2'd2);
        imem[10'h008] = rtype(3'd1, 2'd1, 2'd1, 2'd2);
        imem[10'h009] = itype(OP_SW, 2'd1, 2'd0, 8'h12);
        imem[10'h00A] = itype(OP_SW, 2'd2, 2'd0, 8'h13);
        imem[10'h00B] = itype(OP_LW, 2'd2, 2'd0, 8'h20);
        imem[10'h00C] = itype(OP_SW, 2'd2, 2'd0, 8'h21);
        imem[10'h00D] = jtype(OP_J, 12'h3FE);
        imem[10'h3FF] = jtype(OP_J, 12'h010);
        imem[10'h010] = jtype(OP_JAL, 12'h123);
        imem[10'h123] = itype(OP_JR, 2'd0, 2'd3, 8'h00);
        imem[10'h011] = itype(OP_SW, 2'd3, 2'd0, 8'h14);
        imem[10'h012] = rtype(3'd7, 2'd1, 2'd1, 2'd3);
        imem[10'h013] = rtype(3'd2, 2'd2, 2'd2, 2'd1);
        imem[10'h014] = rtype(3'd3, 2'd2, 2'd2, 2'd3);
        imem[10'h015] = itype(OP_SW, 2'd2, 2'd0, 8'h15);
        imem[10'h016] = itype(OP_SW, 2'd1, 2'd0, 8'h16);
        imem[10'h017] = itype(OP_LW, 2'd1, 2'd0, 8'h30);

        // reset held in FETCH while the zero-wait imem offers valid every cycle
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_pc", 32'(pc), 32'h0);
        chk("rst_ir", 32'(ir), 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'd1);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        chk("rst_zero", {31'b0, zero_flag}, 32'd0);
        chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("rst_state", 32'(fsmState), 32'(FETCH));
        reset = 1'b0;

        step("addi_neg", 10'h001, 4);
        step("addi_pos", 10'h002, 4);
        step("xor", 10'h003, 4);
`ifdef MCDP_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, 32'd12);
        chk("instr_cnt", instr_cnt, 32'd3);
`else
        chk("cycle_cnt", cycle_cnt, 32'd0);
        chk("instr_cnt", instr_cnt, 32'd0);
`endif
        step("j_top", 10'h3FE, 3);
        step("beq_wrap", 10'h004, 3);
        chk("beq_zero", {31'b0, zero_flag}, 32'd1);
        imem[10'h3FE] = itype(OP_BNE, 2'd0, 2'd0, 8'h05);

        exp_q.push_back({10'h011, 16'hFFFD});
        step("sw_addi", 10'h005, 4);
        exp_q.push_back({10'h010, 16'hFFFA});
        step("sw_xor", 10'h006, 4);
        ilat = 2;
        step("slt_iwait", 10'h007, 6);
        ilat = 0;
        step("sll", 10'h008, 4);
        step("sub", 10'h009, 4);
        chk("sub_zero", {31'b0, zero_flag}, 32'd0);
        exp_q.push_back({10'h012, 16'hFFF9});
        step("sw_sub", 10'h00A, 4);
        exp_q.push_back({10'h013, 16'h0001});
        step("sw_slt", 10'h00B, 4);

        // load with three wait states on dmem
        dlat = 3;
        lw_cyc = 0;
        lw_req = 0;
        lw_bad = 0;
        do begin
            @(negedge clk);
            lw_cyc++;
            if (dmem_req === 1'b1) begin
                lw_req++;
                if (dmem_addr !== 10'h020) lw_bad++;
            end
        end while (retire !== 1'b1 && lw_cyc < 200);
        chk("lw_cpi", lw_cyc, 32'd8);
        chk("lw_req_cycles", lw_req, 32'd4);
        chk("lw_addr_stable", lw_bad, 32'd0);
        chk("lw_pc", 32'(pc), 32'h00C);
        dlat = 0;
        exp_q.push_back({10'h021, 16'hBEEF});
        step("sw_lw", 10'h00D, 4);

        step("j_top2", 10'h3FE, 3);
        step("bne_fall", 10'h3FF, 3);
        chk("bne_zero", {31'b0, zero_flag}, 32'd1);
        step("j_jal", 10'h010, 3);
        step("jal", 10'h123, 4);
        step("jr", 10'h011, 3);
        exp_q.push_back({10'h014, 16'h0011});
        step("sw_ra", 10'h012, 4);
        step("srl", 10'h013, 4);
        step("and", 10'h014, 4);
        step("or", 10'h015, 4);
        exp_q.push_back({10'h015, 16'h3EFD});
        step("sw_or", 10'h016, 4);
        exp_q.push_back({10'h016, 16'h7FFC});
        step("sw_srl", 10'h017, 4);
        chk("store_q_drained", 32'(exp_q.size()), 32'd0);
        chk("req_overlap", overlap, 32'd0);

        // reset in the middle of a stalled load
        dlat = 20;
        lw_cyc = 0;
        do begin
            @(negedge clk);
            lw_cyc++;
        end while (dmem_req !== 1'b1 && lw_cyc < 50);
        chk("mem_reached", {31'b0, dmem_req}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_dmem_req", {31'b0, dmem_req}, 32'd0);
        chk("mrst_dmem_we", {31'b0, dmem_we}, 32'd0);
        chk("mrst_pc", 32'(pc), 32'h0);
        chk("mrst_retire", {31'b0, retire}, 32'd0);
        chk("mrst_state", 32'(fsmState), 32'(FETCH));
        chk("mrst_cycle_cnt", cycle_cnt, 32'd0);
        chk("mrst_instr_cnt", instr_cnt, 32'd0);
        reset = 1'b0;
        dlat = 0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multicycle_datapath.md
Name: multicycle_datapath

Overview:
Parametrised multi-cycle successor to the single-cycle 16-bit datapath. It runs one instruction over FETCH/DECODE/EXEC/MEM/WB states and talks to instruction and data memories through req/valid handshakes, so memories of any latency can be used. Control signals come from the external control unit, decoded combinationally from the latched instruction register (ir). Instruction format is unchanged: opcode[15:12], rd[11:10], rs[9:8], rt[7:6], imm8[7:0], jaddr[11:0]; 4 registers, r3 = $ra.

Parameters:
DATA_W, 16, register/ALU/data-memory word width (>=16)
PC_W, 10, PC and memory word-address width (2..16)
RESET_PC, 0, PC value after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
imem_req  out  1  fetch request, held until imem_valid
imem_addr  out  PC_W  fetch address (= pc)
imem_rdata  in  16  fetched instruction
imem_valid  in  1  imem_rdata valid this cycle
ir  out  16  latched instruction, to control unit
reg2_src, reg_dest, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, branch_ne, jump, jump_reg  in  1 each  control from control unit
alu_ctrl  in  3  ALU operation
dmem_req  out  1  data access request, held until dmem_valid
dmem_we  out  1  1 = write
dmem_addr  out  PC_W  alu_out[PC_W-1:0]
dmem_wdata  out  DATA_W  B register
dmem_rdata  in  DATA_W  read data
dmem_valid  in  1  access complete
pc  out  PC_W  architectural PC
zero_flag  out  1  registered ALU zero
retire  out  1  one-cycle pulse when an instruction completes
cycle_cnt, instr_cnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Reset (sync, in any state, including mid-handshake): state=FETCH, pc=RESET_PC, ir=0, zero_flag=0, regs=0, imem_req/dmem_req/dmem_we/retire=0 on the next cycle. A valid arriving after a reset is ignored.
- FETCH: imem_req=1. On imem_valid: ir<=imem_rdata, go to DECODE. Stays in FETCH for any wait length.
- DECODE: A<=reg[rs]; B<=reg[reg2_src ? ir[11:10] : ir[7:6]]. Go to EXEC.
- EXEC: alu_out<=ALU(A, alu_src ? sext(imm8) : B); zero_flag<=(result==0). zero_flag changes only here.
  - If jump, branch, or branch_ne, next pc: jump&jump_reg -> A[PC_W-1:0]; jump -> zero-extended jaddr truncated to PC_W; branch taken ((branch&zero) or (branch_ne&~zero), using this cycle's result) -> pc+1+sext(imm8) mod 2^PC_W; else pc+1. If jump&reg_dest, go to WB; else update pc, pulse retire, go to FETCH.
  - If mem_read or mem_write, go to MEM. Otherwise go to WB.
- MEM: dmem_req=1, dmem_we=mem_write. Address and wdata are stable while waiting. On dmem_valid: a write sets pc<=pc+1, pulses retire, goes to FETCH; a read latches mdr<=dmem_rdata and goes to WB.
- WB: if reg_write: reg[reg_dest ? 3 : ir[11:10]] <= reg_dest ? zext(pc+1) : (mem_to_reg ? mdr : alu_out). pc<=next pc (jump target for JAL, else pc+1). Pulse retire, go to FETCH.
- ALU ops (alu_ctrl): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT signed, 6 SLL by B[3:0], 7 SRL by B[3:0]. Results wrap at DATA_W.
- PC arithmetic wraps modulo 2^PC_W; 2^PC_W-1 +1 -> 0.
- Minimum CPI with zero-wait memories: ALU=4, branch/jump=3, load=5, store=4, JAL=4.
- Only one of imem_req and dmem_req is ever high; each drops in the cycle after its valid.

Optional Feature:
MCDP_PERF_CNT_EN. Defined: cycle_cnt increments every cycle after reset; instr_cnt increments on each retire. Both clear on reset and wrap at 2^32. Undefined: both outputs are constant 0 and no counter flops exist.

Decomposition:
Package mcdp_pkg holds the state enum (FETCH, DECODE, EXEC, MEM, WB), the alu_op_e enum (the 8 ops above), the field-position constants, and RA_IDX=3. One natural sub-module is mcdp_alu (combinational, DATA_W-parametrised, outputs result and zero). The register file and FSM stay in the top module.

Test Plan:
- Reset held during FETCH with imem_valid arriving the same cycle -> pc=RESET_PC, ir=0, imem_req=1 on the next cycle, no retire.
- ADDI r1,r0,-3 (imm8=0xFD), DATA_W=16, zero-wait imem -> r1=0xFFFD, retire after 4 cycles, pc 0->1.
- BEQ with equal operands, imm8=0x05 at pc=0x3FE, PC_W=10 -> pc=0x004 (wrap), retire in 3 cycles. BNE with the same operands -> pc=0x3FF.
- LW with dmem_valid delayed 3 cycles -> dmem_req high for 4 cycles, addr stable; r2=dmem_rdata; CPI=8.
- JAL jaddr=0x123 at pc=0x010 -> r3=0x0011, pc=0x123. Then JR r3 -> pc=0x011.
- MCDP_PERF_CNT_EN defined, 3 ADD instructions with zero-wait memory -> instr_cnt=3, cycle_cnt=12 at the third retire+1. Undefined -> both counters 0.
